// File: rtl/des_sbox_pkg.sv
// Shared definitions for the DES S-box substitution unit: S-box tables, P permutation,
// step-count derivation and FSM state encoding.
package des_sbox_pkg;

  localparam int unsigned DataInW  = 48;
  localparam int unsigned DataOutW = 32;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBusy = 2'd1,
    StDone = 2'd2
  } state_e;

  // Tables in standard DES row-major order (row*16 + column); sbox_lookup() maps the raw
  // 6-bit chunk to that order, so callers index by raw chunk value.
  localparam int unsigned SboxStd [8][64] = '{
    '{14,  4, 13,  1,  2, 15, 11,  8,  3, 10,  6, 12,  5,  9,  0,  7,
       0, 15,  7,  4, 14,  2, 13,  1, 10,  6, 12, 11,  9,  5,  3,  8,
       4,  1, 14,  8, 13,  6,  2, 11, 15, 12,  9,  7,  3, 10,  5,  0,
      15, 12,  8,  2,  4,  9,  1,  7,  5, 11,  3, 14, 10,  0,  6, 13},
    '{15,  1,  8, 14,  6, 11,  3,  4,  9,  7,  2, 13, 12,  0,  5, 10,
       3, 13,  4,  7, 15,  2,  8, 14, 12,  0,  1, 10,  6,  9, 11,  5,
       0, 14,  7, 11, 10,  4, 13,  1,  5,  8, 12,  6,  9,  3,  2, 15,
      13,  8, 10,  1,  3, 15,  4,  2, 11,  6,  7, 12,  0,  5, 14,  9},
    '{10,  0,  9, 14,  6,  3, 15,  5,  1, 13, 12,  7, 11,  4,  2,  8,
      13,  7,  0,  9,  3,  4,  6, 10,  2,  8,  5, 14, 12, 11, 15,  1,
      13,  6,  4,  9,  8, 15,  3,  0, 11,  1,  2, 12,  5, 10, 14,  7,
       1, 10, 13,  0,  6,  9,  8,  7,  4, 15, 14,  3, 11,  5,  2, 12},
    '{ 7, 13, 14,  3,  0,  6,  9, 10,  1,  2,  8,  5, 11, 12,  4, 15,
      13,  8, 11,  5,  6, 15,  0,  3,  4,  7,  2, 12,  1, 10, 14,  9,
      10,  6,  9,  0, 12, 11,  7, 13, 15,  1,  3, 14,  5,  2,  8,  4,
       3, 15,  0,  6, 10,  1, 13,  8,  9,  4,  5, 11, 12,  7,  2, 14},
    '{ 2, 12,  4,  1,  7, 10, 11,  6,  8,  5,  3, 15, 13,  0, 14,  9,
      14, 11,  2, 12,  4,  7, 13,  1,  5,  0, 15, 10,  3,  9,  8,  6,
       4,  2,  1, 11, 10, 13,  7,  8, 15,  9, 12,  5,  6,  3,  0, 14,
      11,  8, 12,  7,  1, 14,  2, 13,  6, 15,  0,  9, 10,  4,  5,  3},
    '{12,  1, 10, 15,  9,  2,  6,  8,  0, 13,  3,  4, 14,  7,  5, 11,
      10, 15,  4,  2,  7, 12,  9,  5,  6,  1, 13, 14,  0, 11,  3,  8,
       9, 14, 15,  5,  2,  8, 12,  3,  7,  0,  4, 10,  1, 13, 11,  6,
       4,  3,  2, 12,  9,  5, 15, 10, 11, 14,  1,  7,  6,  0,  8, 13},
    '{ 4, 11,  2, 14, 15,  0,  8, 13,  3, 12,  9,  7,  5, 10,  6,  1,
      13,  0, 11,  7,  4,  9,  1, 10, 14,  3,  5, 12,  2, 15,  8,  6,
       1,  4, 11, 13, 12,  3,  7, 14, 10, 15,  6,  8,  0,  5,  9,  2,
       6, 11, 13,  8,  1,  4, 10,  7,  9,  5,  0, 15, 14,  2,  3, 12},
    '{13,  2,  8,  4,  6, 15, 11,  1, 10,  9,  3, 14,  5,  0, 12,  7,
       1, 15, 13,  8, 10,  3,  7,  4, 12,  5,  6, 11,  0, 14,  9,  2,
       7, 11,  4,  1,  9, 12, 14,  2,  0,  6, 10, 13, 15,  3,  5,  8,
       2,  1, 14,  7,  4, 10,  8, 13, 15, 12,  9,  0,  3,  5,  6, 11}
  };

  // DES P permutation: output bit i (1 = MSB) takes input bit PermIdx[i-1] (1 = MSB).
  localparam int unsigned PermIdx [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25
  };

  function automatic int unsigned steps_for(int unsigned lanes);
    return (lanes == 0) ? 0 : 8 / lanes;
  endfunction

  // Row = {chunk[5], chunk[0]}, column = chunk[4:1].
  function automatic logic [3:0] sbox_lookup(logic [2:0] box, logic [5:0] chunk);
    return 4'(SboxStd[box][{chunk[5], chunk[0], chunk[4:1]}]);
  endfunction

  // Chunk for box 0 (S1) sits in the top six bits of the half-block.
  function automatic logic [5:0] get_chunk(logic [47:0] data, logic [2:0] box);
    logic [5:0]  sh;
    logic [47:0] shifted;
    sh      = 6'({box, 2'b00}) + 6'({box, 1'b0});
    shifted = data << sh;
    return shifted[47:42];
  endfunction

  function automatic logic [31:0] des_perm(logic [31:0] x);
    logic [31:0] y;
    y = '0;
    for (int unsigned i = 0; i < 32; i++) begin
      y = {y[30:0], 1'(x >> (32 - PermIdx[i]))};
    end
    return y;
  endfunction

endpackage

// File: rtl/des_sbox_if.sv
// Input/output valid-ready handshake bundle for the DES S-box unit.
interface des_sbox_if;
  import des_sbox_pkg::*;

  logic                in_valid;
  logic                in_ready;
  logic [DataInW-1:0]  in_data;
  logic                out_valid;
  logic                out_ready;
  logic [DataOutW-1:0] out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/des_sbox_rom.sv
// Combinational single S-box lookup with runtime box select.
module des_sbox_rom
  import des_sbox_pkg::*;
(
  input  logic [2:0] box_i,
  input  logic [5:0] chunk_i,
  output logic [3:0] nibble_o
);

  assign nibble_o = sbox_lookup(box_i, chunk_i);

endmodule

// File: rtl/des_sbox_unit.sv
// Multi-cycle DES S-box substitution engine, LANES boxes per cycle.
// Optional feature macro: DES_SBOX_PERM_EN applies the DES P permutation on the final write.
module des_sbox_unit
  import des_sbox_pkg::*;
#(
  parameter int unsigned LANES = 2
) (
  input logic       clk,
  input logic       rst,
  des_sbox_if.slave bus
);

  localparam int unsigned STEPS = steps_for(LANES);

  localparam logic [1:0] Idle = StIdle;
  localparam logic [1:0] Busy = StBusy;
  localparam logic [1:0] Done = StDone;

  if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8)) begin : g_bad_lanes
    $error("des_sbox_unit: LANES must be 1, 2, 4 or 8");
  end

  logic [1:0]  state_q, state_d;
  logic [2:0]  step_q, step_d;
  logic [47:0] data_q, data_d;
  logic [31:0] res_q, res_d;
  logic [31:0] out_q, out_d;

  logic        in_ready_w;
  logic        accept;
  logic [2:0]  cur_step;
  logic [47:0] cur_data;
  logic [31:0] merged;
  logic [31:0] final_w;

  logic [2:0] box_sel [LANES];
  logic [5:0] chunk   [LANES];
  logic [3:0] nib     [LANES];

  // Handshake qualifiers; reset masks readiness so a same-cycle handshake is ignored
  always_comb begin
    in_ready_w = !rst && ((state_q == Idle) || ((state_q == Done) && bus.out_ready));
    accept     = bus.in_valid && in_ready_w;
    // Step 0 is evaluated on the accept cycle from the live input
    cur_step   = accept ? 3'd0 : step_q;
    cur_data   = accept ? bus.in_data : data_q;
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign box_sel[l] = 3'(32'(cur_step) * LANES + l);
    assign chunk[l]   = get_chunk(cur_data, box_sel[l]);

    des_sbox_rom u_rom (
      .box_i   (box_sel[l]),
      .chunk_i (chunk[l]),
      .nibble_o(nib[l])
    );
  end

  // Merge this step's nibbles into the partial result (each position written once per block)
  always_comb begin
    merged = accept ? '0 : res_q;
    for (int unsigned l = 0; l < LANES; l++) begin
      merged = merged | (32'(nib[l]) << (5'd28 - {box_sel[l], 2'b00}));
    end
`ifdef DES_SBOX_PERM_EN
    final_w = des_perm(merged);
`else
    final_w = merged;
`endif
  end

  // Next-state: accept, step through BUSY, hold in DONE until consumed
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    data_d  = data_q;
    res_d   = res_q;
    out_d   = out_q;
    if (accept) begin
      data_d = bus.in_data;
      res_d  = merged;
      if (STEPS == 1) begin
        state_d = Done;
        step_d  = '0;
        out_d   = final_w;
      end else begin
        state_d = Busy;
        step_d  = 3'd1;
      end
    end else if (state_q == Busy) begin
      res_d = merged;
      if (step_q == 3'(STEPS - 1)) begin
        state_d = Done;
        step_d  = '0;
        out_d   = final_w;
      end else begin
        step_d = step_q + 3'd1;
      end
    end else if (state_q == Done) begin
      if (bus.out_ready) begin
        state_d = Idle;
      end
    end else if (state_q != Idle) begin
      state_d = Idle;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= Idle;
      step_q  <= '0;
      data_q  <= '0;
      res_q   <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      data_q  <= data_d;
      res_q   <= res_d;
      out_q   <= out_d;
    end
  end

  assign bus.in_ready  = in_ready_w;
  assign bus.out_valid = (state_q == Done);
  assign bus.out_data  = out_q;

endmodule

// File: tb/tb_des_sbox_unit.sv
// Self-checking bench: one DUT per legal LANES value (1, 2, 4, 8), scoreboard-based.
module tb_des_sbox_unit;
  import des_sbox_pkg::*;

  localparam int NDut = 4;

  logic        clk;
  logic        rst;
  logic        in_valid  [NDut];
  logic        in_ready  [NDut];
  logic [47:0] in_data   [NDut];
  logic        out_valid [NDut];
  logic        out_ready [NDut];
  logic [31:0] out_data  [NDut];

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] sb [$];

  for (genvar g = 0; g < NDut; g++) begin : g_dut
    des_sbox_if u_if ();
    assign u_if.in_valid  = in_valid[g];
    assign u_if.in_data   = in_data[g];
    assign u_if.out_ready = out_ready[g];
    assign in_ready[g]    = u_if.in_ready;
    assign out_valid[g]   = u_if.out_valid;
    assign out_data[g]    = u_if.out_data;

    des_sbox_unit #(.LANES(1 << g)) u_dut (
      .clk(clk),
      .rst(rst),
      .bus(u_if.slave)
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] gold(logic [31:0] raw);
`ifdef DES_SBOX_PERM_EN
    return des_perm(raw);
`else
    return raw;
`endif
  endfunction

  function automatic logic [31:0] model(logic [47:0] d);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      r = (r << 4) | 32'(sbox_lookup(3'(i), 6'(d >> (42 - 6 * i))));
    end
    return gold(r);
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int d = 0; d < NDut; d++) begin
      in_valid[d] = 1'b0; out_ready[d] = 1'b0; in_data[d] = '0;
    end
    repeat (3) cyc();
    for (int d = 0; d < NDut; d++) begin
      n_checks++;
      if (out_valid[d] !== 1'b0) $display("FAIL reset_out_valid d%0d: got %b want 0", d, out_valid[d]);
      else n_pass++;
      n_checks++;
      if (out_data[d] !== 32'h0) $display("FAIL reset_out_data d%0d: got %h want 0", d, out_data[d]);
      else n_pass++;
      n_checks++;
      if (in_ready[d] !== 1'b0) $display("FAIL reset_in_ready d%0d: got %b want 0", d, in_ready[d]);
      else n_pass++;
    end
    rst = 1'b0;
    #1;
    for (int d = 0; d < NDut; d++) begin
      n_checks++;
      if (in_ready[d] !== 1'b1) $display("FAIL post_reset_ready d%0d: got %b want 1", d, in_ready[d]);
      else n_pass++;
    end
  endtask

  task automatic test_latency();
    logic [47:0] vin  [4] = '{48'h0, 48'hFFFF_FFFF_FFFF, 48'h40, 48'hFC0};
    logic [31:0] vout [4] = '{32'hEFA72C4D, 32'hD9CE3DCB, 32'hEFA72CDD, 32'hEFA72CCD};
    int n;
    for (int d = 0; d < NDut; d++) begin
      for (int k = 0; k < 4; k++) begin
        in_data[d] = vin[k]; in_valid[d] = 1'b1;
        #1;
        n_checks++;
        if (in_ready[d] !== 1'b1) $display("FAIL lat_ready d%0d: got %b want 1", d, in_ready[d]);
        else n_pass++;
        cyc();
        in_valid[d] = 1'b0;
        n = 1;
        while (!out_valid[d] && n < 20) begin cyc(); n++; end
        n_checks++;
        if (n !== (8 >> d)) $display("FAIL latency d%0d v%0d: got %0d want %0d", d, k, n, 8 >> d);
        else n_pass++;
        n_checks++;
        if (out_data[d] !== gold(vout[k]))
          $display("FAIL lat_data d%0d v%0d: got %h want %h", d, k, out_data[d], gold(vout[k]));
        else n_pass++;
        out_ready[d] = 1'b1;
        cyc();
        out_ready[d] = 1'b0;
        #1;
        n_checks++;
        if (out_valid[d] !== 1'b0) $display("FAIL lat_idle d%0d: got %b want 0", d, out_valid[d]);
        else n_pass++;
        cyc();
      end
    end
  endtask

  task automatic test_back_to_back();
    int d = 3;
    int acc = 0;
    int got = 0;
    logic [31:0] exp;
    sb.delete();
    out_ready[d] = 1'b1;
    for (int c = 0; c < 11; c++) begin
      in_valid[d] = (acc < 10);
      in_data[d]  = {16'($urandom), $urandom};
      #1;
      if (out_valid[d] && out_ready[d]) begin
        got++;
        n_checks++;
        if (sb.size() == 0) $display("FAIL b2b_extra: got %h want none", out_data[d]);
        else begin
          exp = sb.pop_front();
          if (out_data[d] !== exp) $display("FAIL b2b_data: got %h want %h", out_data[d], exp);
          else n_pass++;
        end
      end
      if (in_valid[d] && in_ready[d]) begin sb.push_back(model(in_data[d])); acc++; end
      cyc();
    end
    in_valid[d] = 1'b0; out_ready[d] = 1'b0;
    n_checks++;
    if (acc !== 10) $display("FAIL b2b_accepts: got %0d want 10", acc);
    else n_pass++;
    n_checks++;
    if (got !== 10) $display("FAIL b2b_results: got %0d want 10", got);
    else n_pass++;
    cyc();
  endtask

  task automatic test_stall();
    int d = 0;
    int n = 0;
    in_data[d] = 48'hFFFF_FFFF_FFFF; in_valid[d] = 1'b1;
    cyc();
    in_valid[d] = 1'b0;
    while (!out_valid[d] && n < 20) begin cyc(); n++; end
    n_checks++;
    if (out_valid[d] !== 1'b1) $display("FAIL stall_done: got %b want 1", out_valid[d]);
    else n_pass++;
    in_valid[d] = 1'b1; in_data[d] = 48'h0; out_ready[d] = 1'b0;
    for (int c = 0; c < 20; c++) begin
      #1;
      n_checks++;
      if (out_data[d] !== gold(32'hD9CE3DCB))
        $display("FAIL stall_data c%0d: got %h want %h", c, out_data[d], gold(32'hD9CE3DCB));
      else n_pass++;
      n_checks++;
      if (in_ready[d] !== 1'b0) $display("FAIL stall_ready c%0d: got %b want 0", c, in_ready[d]);
      else n_pass++;
      n_checks++;
      if (out_valid[d] !== 1'b1) $display("FAIL stall_valid c%0d: got %b want 1", c, out_valid[d]);
      else n_pass++;
      cyc();
    end
    in_valid[d] = 1'b0; out_ready[d] = 1'b1;
    #1;
    n_checks++;
    if (in_ready[d] !== 1'b1) $display("FAIL release_ready: got %b want 1", in_ready[d]);
    else n_pass++;
    cyc();
    out_ready[d] = 1'b0;
    #1;
    n_checks++;
    if (out_valid[d] !== 1'b0) $display("FAIL release_idle_valid: got %b want 0", out_valid[d]);
    else n_pass++;
    n_checks++;
    if (in_ready[d] !== 1'b1) $display("FAIL release_idle_ready: got %b want 1", in_ready[d]);
    else n_pass++;
    cyc();
  endtask

  task automatic test_reset_midbusy();
    int d = 2;
    int n;
    in_data[d] = 48'hFFFF_FFFF_FFFF; in_valid[d] = 1'b1;
    cyc();
    in_valid[d] = 1'b0;
    rst = 1'b1;
    cyc();
    for (int c = 0; c < 3; c++) begin
      n_checks++;
      if (out_valid[d] !== 1'b0) $display("FAIL midbusy_valid c%0d: got %b want 0", c, out_valid[d]);
      else n_pass++;
      cyc();
    end
    n_checks++;
    if (out_data[d] !== 32'h0) $display("FAIL midbusy_data: got %h want 0", out_data[d]);
    else n_pass++;
    rst = 1'b0;
    in_data[d] = 48'h0; in_valid[d] = 1'b1;
    cyc();
    in_valid[d] = 1'b0;
    n = 1;
    while (!out_valid[d] && n < 20) begin cyc(); n++; end
    n_checks++;
    if (n !== 2) $display("FAIL midbusy_latency: got %0d want 2", n);
    else n_pass++;
    n_checks++;
    if (out_data[d] !== gold(32'hEFA72C4D))
      $display("FAIL midbusy_next: got %h want %h", out_data[d], gold(32'hEFA72C4D));
    else n_pass++;
    out_ready[d] = 1'b1;
    cyc();
    out_ready[d] = 1'b0;
    cyc();
  endtask

  task automatic test_exhaustive();
    logic [31:0] exp;
    logic [5:0]  v6;
    int v, got;
    for (int d = 0; d < NDut; d++) begin
      sb.delete(); v = 0; got = 0;
      out_ready[d] = 1'b1;
      for (int c = 0; c < 1000 && got < 64; c++) begin
        v6 = 6'(v);
        in_valid[d] = (v < 64);
        in_data[d]  = {8{v6}};
        #1;
        if (out_valid[d] && out_ready[d]) begin
          got++;
          n_checks++;
          if (sb.size() == 0) $display("FAIL exh_extra d%0d: got %h", d, out_data[d]);
          else begin
            exp = sb.pop_front();
            if (out_data[d] !== exp)
              $display("FAIL exh_data d%0d idx%0d: got %h want %h", d, got - 1, out_data[d], exp);
            else n_pass++;
          end
        end
        if (in_valid[d] && in_ready[d]) begin sb.push_back(model(in_data[d])); v++; end
        cyc();
      end
      in_valid[d] = 1'b0; out_ready[d] = 1'b0;
      n_checks++;
      if (got !== 64) $display("FAIL exh_count d%0d: got %0d want 64", d, got);
      else n_pass++;
      cyc();
    end
  endtask

  task automatic test_random();
    logic [31:0] exp;
    int acc, got;
    for (int d = 0; d < NDut; d++) begin
      sb.delete(); acc = 0; got = 0;
      for (int c = 0; c < 3000 && got < 30; c++) begin
        out_ready[d] = 1'($urandom_range(0, 1));
        in_valid[d]  = (acc < 30) && ($urandom_range(0, 9) < 6);
        in_data[d]   = {16'($urandom), $urandom};
        #1;
        if (out_valid[d] && out_ready[d]) begin
          got++;
          n_checks++;
          if (sb.size() == 0) $display("FAIL rnd_extra d%0d: got %h", d, out_data[d]);
          else begin
            exp = sb.pop_front();
            if (out_data[d] !== exp)
              $display("FAIL rnd_data d%0d: got %h want %h", d, out_data[d], exp);
            else n_pass++;
          end
        end
        if (in_valid[d] && in_ready[d]) begin sb.push_back(model(in_data[d])); acc++; end
        cyc();
      end
      in_valid[d] = 1'b0; out_ready[d] = 1'b0;
      n_checks++;
      if (got !== 30 || sb.size() != 0)
        $display("FAIL rnd_count d%0d: got %0d left %0d want 30 left 0", d, got, sb.size());
      else n_pass++;
      cyc();
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_back_to_back();
    test_stall();
    test_reset_midbusy();
    test_exhaustive();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
